// File: rtl/jpegls_pkg.sv
// Shared JPEG-LS encoder definitions: default widths, packer FSM encoding
// and the marker byte that triggers bit stuffing.
package jpegls_pkg;

  localparam int default_encodedpixel_width  = 32;
  localparam int default_encodedlength_width = 6;
  localparam int default_buffer_width        = 64;

  localparam logic [7:0] marker_ff = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } packer_state_t;

endpackage

// File: rtl/encode_byte_stuffer.sv
// Forms the next stream byte from the accumulator top bits, applying the
// forced-zero MSB after a 0xFF byte and zero padding during a flush.
module encode_byte_stuffer
  import jpegls_pkg::*;
#(
  parameter int fill_w = 7
) (
  input  logic [7:0]        top_bits,
  input  logic [fill_w-1:0] fill,
  input  logic              last_ff,
  input  logic              pad,
  output logic [7:0]        stuffed_byte,
  output logic              byte_ok,
  output logic [3:0]        consume,
  output logic              next_last_ff
);

  logic [3:0] need;

  always_comb begin
    need         = last_ff ? 4'd7 : 4'd8;
    stuffed_byte = last_ff ? {1'b0, top_bits[7:1]} : top_bits;
    byte_ok      = 1'b0;
    consume      = 4'd0;
    if (fill >= fill_w'(need)) begin
      byte_ok = 1'b1;
      consume = need;
    end else if (pad && (fill != '0 || last_ff)) begin
      // Bits below fill are always zero, so the top bits are already padded;
      // with fill == 0 after 0xFF this yields the terminating 0x00.
      byte_ok = 1'b1;
      consume = fill[3:0];
    end
    next_last_ff = (stuffed_byte == marker_ff);
  end

endmodule

// File: rtl/encode_bit_packer.sv
// Packs right-aligned variable-length code words MSB-first into a stuffed
// JPEG-LS byte stream, with an end-of-scan flush handshake.
module encode_bit_packer
  import jpegls_pkg::*;
#(
  parameter int encodedpixel_width  = default_encodedpixel_width,
  parameter int encodedlength_width = default_encodedlength_width,
  parameter int buffer_width        = default_buffer_width
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [encodedpixel_width-1:0]  encoded_pixel,
  input  logic [encodedlength_width-1:0] encoded_length,
  input  logic                           flush_req,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_byte,
  output logic                           flush_done
);

  localparam int fill_w = 7;

  packer_state_t state, state_nxt;

  logic [buffer_width-1:0]       acc, acc_shift, word_ext, acc_nxt;
  logic [fill_w-1:0]             fill, fill_mid, fill_nxt;
  logic                          last_ff;
  logic [encodedpixel_width-1:0] word_left;
  logic [encodedlength_width:0]  word_shift;
  logic [7:0]                    stuffed_byte;
  logic                          byte_ok, next_last_ff, fire, accept;
  logic [3:0]                    consume, consume_eff;

  encode_byte_stuffer #(.fill_w(fill_w)) u_stuffer (
    .top_bits     (acc[buffer_width-1 -: 8]),
    .fill         (fill),
    .last_ff      (last_ff),
    .pad          (state == ST_FLUSH),
    .stuffed_byte (stuffed_byte),
    .byte_ok      (byte_ok),
    .consume      (consume),
    .next_last_ff (next_last_ff)
  );

  assign in_ready   = (state == ST_RUN) && (fill <= fill_w'(buffer_width - encodedpixel_width));
  assign accept     = in_valid && in_ready;
  assign fire       = (!out_valid || out_ready) && byte_ok;
  assign flush_done = (state == ST_DONE);

  // Extract first, then append the new word directly below the surviving bits.
  always_comb begin
    consume_eff = fire ? consume : 4'd0;
    acc_shift   = acc << consume_eff;
    fill_mid    = fill - fill_w'(consume_eff);
    // Left-aligning the word drops any bits above its length.
    word_shift  = (encodedlength_width+1)'(encodedpixel_width) - {1'b0, encoded_length};
    word_left   = encoded_pixel << word_shift;
    word_ext    = {word_left, {(buffer_width-encodedpixel_width){1'b0}}} >> fill_mid;
    acc_nxt     = accept ? (acc_shift | word_ext) : acc_shift;
    fill_nxt    = fill_mid + (accept ? fill_w'(encoded_length) : '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_FLUSH;
      ST_FLUSH: if (fill == '0 && !last_ff && !out_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      acc       <= '0;
      fill      <= '0;
      last_ff   <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
      if (state == ST_DONE)
        last_ff <= 1'b0;
      else if (fire)
        last_ff <= next_last_ff;
      if (fire) begin
        out_valid <= 1'b1;
        out_byte  <= stuffed_byte;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encode_bit_packer.sv
// Bench for encode_bit_packer: directed scenarios plus random words, checked
// against a bit-queue model of the stuffed byte stream.
module tb_encode_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] encoded_pixel = '0;
  logic [5:0]  encoded_length = '0;
  logic        flush_req = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        flush_done;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 1;

  bit         mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         got_base = 0;
  bit         mlast_ff = 1'b0;

  encode_bit_packer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .encoded_pixel  (encoded_pixel),
    .encoded_length (encoded_length),
    .flush_req      (flush_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .flush_done     (flush_done)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk)
    if (out_valid && out_ready) got.push_back(out_byte);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Stream model: ordered bit queue, bytes taken greedily with stuffing rule.
  function automatic void model_emit(input bit pad);
    int need;
    logic [7:0] b;
    while (1) begin
      need = mlast_ff ? 7 : 8;
      if (mq.size() >= need || (pad && (mq.size() > 0 || mlast_ff))) begin
        b = 8'h00;
        for (int i = 0; i < need; i++) begin
          if (mq.size() > 0) b = {b[6:0], mq.pop_front()};
          else               b = {b[6:0], 1'b0};
        end
        exp_q.push_back(b);
        mlast_ff = (b == 8'hFF);
      end else begin
        break;
      end
    end
  endfunction

  task automatic send(input logic [31:0] pix, input int len);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid       = 1'b1;
    encoded_pixel  = pix;
    encoded_length = 6'(len);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      for (int i = len - 1; i >= 0; i--) mq.push_back(pix[i]);
      model_emit(1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_byte_count", tag), 32'(got.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_base + i < got.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(got[got_base + i]), 32'(exp_q[i]));
    got_base = got.size();
    exp_q.delete();
  endtask

  task automatic flush_and_check(input string tag);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    model_emit(1'b1);
    mlast_ff = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (flush_done) seen = 1'b1;
    end
    chk($sformatf("%s_flush_done", tag), 32'(seen), 32'd1);
    @(negedge clk);
    chk($sformatf("%s_flush_pulse_width", tag), 32'(flush_done), 32'd0);
    chk($sformatf("%s_idle_out_valid", tag), 32'(out_valid), 32'd0);
    check_stream(tag);
  endtask

  initial begin
    int seg_base;
    int ones;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_byte", 32'(out_byte), 32'h00);
    chk("reset_flush_done", 32'(flush_done), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    rdy_mode = 1;
    send(32'b101, 3);
    send(32'b11111, 5);
    flush_and_check("t1_bf");

    send(32'hFF, 8);
    send(32'h7F, 7);
    flush_and_check("t2_stuff");

    send(32'b10110, 5);
    flush_and_check("t3_pad");

    send(32'hFF, 8);
    flush_and_check("t4_ff_term");

    // Output stalled while full-width words arrive.
    rdy_mode = 0;
    seg_base = got_base;
    send(32'hFFFFFFFF, 32);
    send(32'hFFFFFFFF, 32);
    in_valid       = 1'b1;
    encoded_pixel  = 32'hFFFFFFFF;
    encoded_length = 6'd32;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("t5_in_ready_full_c%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("t5_out_valid_hold_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("t5_out_byte_hold_c%0d", c), 32'(out_byte), 32'(exp_q[0]));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    send(32'hFFFFFFFF, 32);
    send(32'hFFFFFFFF, 32);
    send(32'hFFFFFFFF, 32);
    flush_and_check("t5_stall");
    ones = 0;
    for (int i = seg_base; i < got.size(); i++) ones += $countones(got[i]);
    chk("t5_payload_bits", 32'(ones), 32'd160);

    // Reset while fill is 13 and a byte is pending.
    rdy_mode = 0;
    send(32'h0015A5A5, 21);
    @(posedge clk);
    @(negedge clk);
    chk("t6_pre_reset_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_out_byte", 32'(out_byte), 32'h00);
    chk("t6_rst_flush_done", 32'(flush_done), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
    mlast_ff = 1'b0;
    got_base = got.size();
    rdy_mode = 1;
    send(32'hA5, 8);
    flush_and_check("t6_after_reset");

    // Random words with random consumer back-pressure.
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 30; k++)
        send($urandom, int'($urandom_range(0, 32)));
      flush_and_check($sformatf("t7_rand%0d", r));
    end
    rdy_mode = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
